lcd_byte_writer: RTL and testbench
==================================

# lcd_byte_writer

Sequencer for the 4-bit character-LCD bus on the 50 MHz board. It accepts one byte (command or data) per valid/ready handshake and splits it into two nibble writes, high nibble first. It generates the setup, enable-pulse, hold and inter-nibble timing, then waits out the LCD execution time. It produces the write-done pulse consumed by the LCD init and text controllers, and is the only block that drives the LCD pins.

## Interface
Parameters:
- SETUP_CYC, 2: cycles data/RS are stable before E rises (40 ns)
- ENABLE_CYC, 12: E high width (240 ns)
- HOLD_CYC, 1: cycles data/RS held after E falls
- NIBBLE_GAP_CYC, 50: gap between high and low nibble (1 µs)
- CMD_WAIT_CYC, 2000: post-write execution wait (40 µs)
- LONG_WAIT_CYC, 82000: post-write wait for clear/home (1.64 ms)

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high
- iValid  in  1  request valid
- oReady  out  1  high only in IDLE
- iData  in  8  byte to write
- iRegisterSelect  in  1  0 = command, 1 = data
- iNibbleOnly  in  1  write only iData[3:0] (init sequence)
- oWriteDone  out  1  one-cycle pulse at end of transaction
- oLCD_Enabled  out  1  LCD E
- oLCD_RegisterSelect  out  1  LCD RS
- oLCD_ReadWrite  out  1  constant 0
- oLCD_Data  out  4  LCD DB[7:4]

## Operation
- Transfer occurs on an edge with iValid && oReady. At that edge iData, iRegisterSelect and iNibbleOnly are latched, and the long-wait flag is set when RS=0 and iData[7:1]==7'b0000_001 (0x02/0x03) or iData==0x01.
- State sequence: IDLE → SETUP_HI → EN_HI → HOLD_HI → GAP → SETUP_LO → EN_LO → HOLD_LO → WAIT → DONE → IDLE.
- With iNibbleOnly, the sequence is IDLE → SETUP_LO → EN_LO → HOLD_LO → WAIT → DONE, and it sends latched [3:0].
- oLCD_Data shows the high nibble from SETUP_HI through GAP, and the low nibble from SETUP_LO through DONE. It reads 0 in IDLE.
- oLCD_RegisterSelect shows the latched RS from SETUP_HI (or SETUP_LO) through DONE, and reads 0 in IDLE.
- oLCD_Enabled is 1 only in EN_HI and EN_LO.
- The WAIT length is LONG_WAIT_CYC if the long-wait flag is set, otherwise CMD_WAIT_CYC.
- oWriteDone is 1 only in DONE. oReady is 1 only in IDLE.
- iValid while busy is ignored and not queued. Input changes after the transfer have no effect.
- Reset at any state forces IDLE at the next edge. The transaction is aborted and no oWriteDone is produced.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- After the reset edge: oReady=1, oWriteDone=0, oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oLCD_ReadWrite=0.
- Each timed state lasts exactly its parameter count in cycles. DONE lasts 1 cycle.
- Full byte, short wait, transfer at edge E0: state is DONE after E0+2080, oWriteDone is sampled high at E0+2081, and oReady is sampled high at E0+2082.
- Full byte, long wait: oWriteDone is sampled at E0+82081.
- Nibble-only: oWriteDone is sampled at E0+2016.
- Back-to-back: the earliest next transfer is edge E0+2082 (short wait).
- The counter is 17 bits, a loadable down-counter. It is loaded with N-1 on state entry and advances on reaching 0.

## Structure
- Shared package lcd_pkg holds:
  - state encodings
  - default timing constants
  - command codes LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME=8'h02
  - the 50 MHz clock constant
- Sub-module lcd_cycle_timer: a 17-bit loadable down-counter with load and zero outputs. It is reused by the init controller.

## Test plan
- Reset, then write 0x28 with RS=0 → two E pulses of 12 cycles each, data 0x2 then 0x8, RS=0, oWriteDone at E0+2081.
- Write 0x01 with RS=0 → long wait, oWriteDone at E0+82081, E pulses carry data 0x0 and 0x1.
- Write 0x03 with iNibbleOnly=1 → a single E pulse with data 0x3, oWriteDone at E0+2016.
- Write 0x41 with RS=1 → RS=1 throughout, data 0x4 then 0x1, short wait (RS=1 suppresses long wait), oWriteDone at E0+2081.
- Hold iValid high with two queued bytes, and toggle iData mid-transaction → second transfer at E0+2082, first byte's nibbles unchanged.
- Assert Reset during EN_LO → E=0 and oReady=1 at the next edge, no oWriteDone pulse, and a following write completes normally.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD blocks: state encodings, default
// bus timing at 50 MHz, command codes and the long-execution command test.
package lcd_pkg;

  localparam int unsigned LCD_CLK_HZ  = 50_000_000;
  localparam int unsigned LCD_TIMER_W = 17;

  localparam int unsigned LCD_SETUP_CYC      = 2;
  localparam int unsigned LCD_ENABLE_CYC     = 12;
  localparam int unsigned LCD_HOLD_CYC       = 1;
  localparam int unsigned LCD_NIBBLE_GAP_CYC = 50;
  localparam int unsigned LCD_CMD_WAIT_CYC   = 2000;
  localparam int unsigned LCD_LONG_WAIT_CYC  = 82000;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP_HI,
    ST_EN_HI,
    ST_HOLD_HI,
    ST_GAP,
    ST_SETUP_LO,
    ST_EN_LO,
    ST_HOLD_LO,
    ST_WAIT,
    ST_DONE
  } lcd_state_e;

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data[7:1] == 7'b0000_001) || (data == LCD_CMD_CLEAR));
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module lcd_cycle_timer
  import lcd_pkg::*;
#(
  parameter int unsigned W = LCD_TIMER_W
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         iLoad,
  input  logic [W-1:0] iLoadValue,
  output logic         oZero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (iLoad)
      count_d = iLoadValue;
    else if (count_q != '0)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign oZero = (count_q == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// Splits one byte into two 4-bit LCD bus writes with setup/enable/hold/gap
// timing, then waits out the execution time and pulses oWriteDone.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = LCD_SETUP_CYC,
  parameter int unsigned ENABLE_CYC     = LCD_ENABLE_CYC,
  parameter int unsigned HOLD_CYC       = LCD_HOLD_CYC,
  parameter int unsigned NIBBLE_GAP_CYC = LCD_NIBBLE_GAP_CYC,
  parameter int unsigned CMD_WAIT_CYC   = LCD_CMD_WAIT_CYC,
  parameter int unsigned LONG_WAIT_CYC  = LCD_LONG_WAIT_CYC
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  output logic       oReady,
  input  logic [7:0] iData,
  input  logic       iRegisterSelect,
  input  logic       iNibbleOnly,
  output logic       oWriteDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic [3:0] oLCD_Data
);

  localparam logic [LCD_TIMER_W-1:0] SETUP_LD = LCD_TIMER_W'(SETUP_CYC - 1);
  localparam logic [LCD_TIMER_W-1:0] EN_LD    = LCD_TIMER_W'(ENABLE_CYC - 1);
  localparam logic [LCD_TIMER_W-1:0] HOLD_LD  = LCD_TIMER_W'(HOLD_CYC - 1);
  localparam logic [LCD_TIMER_W-1:0] GAP_LD   = LCD_TIMER_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [LCD_TIMER_W-1:0] CMD_LD   = LCD_TIMER_W'(CMD_WAIT_CYC - 1);
  localparam logic [LCD_TIMER_W-1:0] LONG_LD  = LCD_TIMER_W'(LONG_WAIT_CYC - 1);

  lcd_state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;
  logic       long_wait_q, long_wait_d;

  logic                   timer_load;
  logic [LCD_TIMER_W-1:0] timer_value;
  logic                   timer_zero;

  lcd_cycle_timer #(.W(LCD_TIMER_W)) u_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .iLoad      (timer_load),
    .iLoadValue (timer_value),
    .oZero      (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rs_d        = rs_q;
    long_wait_d = long_wait_q;
    timer_load  = 1'b0;
    timer_value = SETUP_LD;
    unique case (state_q)
      ST_IDLE: if (iValid) begin
        data_d      = iData;
        rs_d        = iRegisterSelect;
        long_wait_d = !iNibbleOnly && lcd_is_long_cmd(iRegisterSelect, iData);
        timer_load  = 1'b1;
        state_d     = iNibbleOnly ? ST_SETUP_LO : ST_SETUP_HI;
      end
      ST_SETUP_HI: if (timer_zero) begin
        state_d = ST_EN_HI; timer_load = 1'b1; timer_value = EN_LD;
      end
      ST_EN_HI: if (timer_zero) begin
        state_d = ST_HOLD_HI; timer_load = 1'b1; timer_value = HOLD_LD;
      end
      ST_HOLD_HI: if (timer_zero) begin
        state_d = ST_GAP; timer_load = 1'b1; timer_value = GAP_LD;
      end
      ST_GAP: if (timer_zero) begin
        state_d = ST_SETUP_LO; timer_load = 1'b1; timer_value = SETUP_LD;
      end
      ST_SETUP_LO: if (timer_zero) begin
        state_d = ST_EN_LO; timer_load = 1'b1; timer_value = EN_LD;
      end
      ST_EN_LO: if (timer_zero) begin
        state_d = ST_HOLD_LO; timer_load = 1'b1; timer_value = HOLD_LD;
      end
      ST_HOLD_LO: if (timer_zero) begin
        state_d = ST_WAIT; timer_load = 1'b1;
        timer_value = long_wait_q ? LONG_LD : CMD_LD;
      end
      ST_WAIT: if (timer_zero) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      rs_q        <= 1'b0;
      long_wait_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      long_wait_q <= long_wait_d;
    end
  end

  logic idle, hi_phase;

  always_comb begin
    idle     = (state_q == ST_IDLE);
    hi_phase = (state_q == ST_SETUP_HI) || (state_q == ST_EN_HI) ||
               (state_q == ST_HOLD_HI)  || (state_q == ST_GAP);
    oReady              = idle;
    oWriteDone          = (state_q == ST_DONE);
    oLCD_Enabled        = (state_q == ST_EN_HI) || (state_q == ST_EN_LO);
    oLCD_RegisterSelect = idle ? 1'b0 : rs_q;
    oLCD_ReadWrite      = 1'b0;
    oLCD_Data           = idle ? 4'h0 : (hi_phase ? data_q[7:4] : data_q[3:0]);
  end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Randomised bench for lcd_byte_writer against a timeline model of the bus.
module tb_lcd_byte_writer;

  localparam int unsigned SU = 2, EN = 12, HD = 1, GP = 50, CW = 2000;
  localparam int unsigned TB_LONG = 8200;

  logic       Clock = 1'b0;
  logic       Reset, iValid, iRegisterSelect, iNibbleOnly;
  logic [7:0] iData;
  logic       oReady, oWriteDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite;
  logic [3:0] oLCD_Data;

  always #10 Clock = ~Clock;

  lcd_byte_writer #(.LONG_WAIT_CYC(TB_LONG)) dut (
    .Clock               (Clock),
    .Reset               (Reset),
    .iValid              (iValid),
    .oReady              (oReady),
    .iData               (iData),
    .iRegisterSelect     (iRegisterSelect),
    .iNibbleOnly         (iNibbleOnly),
    .oWriteDone          (oWriteDone),
    .oLCD_Enabled        (oLCD_Enabled),
    .oLCD_RegisterSelect (oLCD_RegisterSelect),
    .oLCD_ReadWrite      (oLCD_ReadWrite),
    .oLCD_Data           (oLCD_Data)
  );

  int unsigned n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is a timeline of k = edges since the transfer edge.
  bit         m_init = 0, m_busy = 0;
  bit         m_rs, m_nib, m_long;
  logic [7:0] m_byte;
  int         m_k, m_t0, edge_n = 0;

  function automatic int total_len(input bit nib, input bit lng);
    return (nib ? 0 : SU + EN + HD + GP) + SU + EN + HD + (lng ? TB_LONG : CW);
  endfunction

  initial forever begin
    int base, t;
    bit e_exp;
    logic [3:0] d_exp;
    @(posedge Clock);
    edge_n++;
    if (Reset) begin
      m_init = 1; m_busy = 0;
    end else if (m_busy) begin
      m_k++;
      if (m_k > total_len(m_nib, m_long)) m_busy = 0;
    end else if (m_init && iValid) begin
      m_busy = 1; m_k = 0; m_t0 = edge_n;
      m_byte = iData; m_rs = iRegisterSelect; m_nib = iNibbleOnly;
      m_long = !iRegisterSelect && !iNibbleOnly && (iData >= 8'd1 && iData <= 8'd3);
    end
    #1;
    if (m_init) begin
      t     = total_len(m_nib, m_long);
      base  = m_nib ? 0 : SU + EN + HD + GP;
      e_exp = m_busy && ((!m_nib && m_k >= SU && m_k < SU + EN) ||
                         (m_k >= base + SU && m_k < base + SU + EN));
      d_exp = !m_busy ? 4'h0 : ((!m_nib && m_k < base) ? m_byte[7:4] : m_byte[3:0]);
      check("ready", oReady, !m_busy);
      check("write_done", oWriteDone, m_busy && m_k == t);
      check("lcd_e", oLCD_Enabled, e_exp);
      check("lcd_rs", oLCD_RegisterSelect, m_busy && m_rs);
      check("lcd_rw", oLCD_ReadWrite, 1'b0);
      check("lcd_data", oLCD_Data, d_exp);
      if (m_busy && m_k == t && oWriteDone === 1'b1)
        check("done_latency", edge_n - m_t0 + 1, m_nib ? 2016 : (m_long ? 8281 : 2081));
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20000; i++) begin
      @(negedge Clock);
      if (oReady === 1'b1) return;
    end
    n_checks++; n_fail++;
    $display("FAIL ready_timeout: oReady never returned high at %0t", $time);
  endtask

  // Returns #1 after the transfer edge (k = 0).
  task automatic send(input logic [7:0] b, input logic rs, input logic nib);
    wait_ready();
    iValid = 1'b1; iData = b; iRegisterSelect = rs; iNibbleOnly = nib;
    @(posedge Clock); #1;
    iValid = 1'b0; iData = 8'($urandom); iRegisterSelect = 1'($urandom);
    iNibbleOnly = 1'($urandom);
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  initial begin
    int n;
    Reset = 1'b1; iValid = 1'b0; iData = '0; iRegisterSelect = 1'b0; iNibbleOnly = 1'b0;
    repeat (3) @(posedge Clock);
    #2;
    check("rst_ready", oReady, 1'b1);
    check("rst_done", oWriteDone, 1'b0);
    check("rst_e", oLCD_Enabled, 1'b0);
    check("rst_rs", oLCD_RegisterSelect, 1'b0);
    check("rst_data", oLCD_Data, 4'h0);
    check("rst_rw", oLCD_ReadWrite, 1'b0);
    Reset = 1'b0;

    send(8'h28, 1'b0, 1'b0);
    advance(5);  check("b28_hi_e", oLCD_Enabled, 1'b1); check("b28_hi", oLCD_Data, 4'h2);
    check("b28_rs", oLCD_RegisterSelect, 1'b0);
    advance(65); check("b28_lo_e", oLCD_Enabled, 1'b1); check("b28_lo", oLCD_Data, 4'h8);

    send(8'h01, 1'b0, 1'b0);
    advance(5);  check("b01_hi", oLCD_Data, 4'h0);
    advance(65); check("b01_lo_e", oLCD_Enabled, 1'b1); check("b01_lo", oLCD_Data, 4'h1);

    send(8'h03, 1'b0, 1'b1);
    advance(5);  check("n03_e", oLCD_Enabled, 1'b1); check("n03_data", oLCD_Data, 4'h3);
    advance(15); check("n03_e_off", oLCD_Enabled, 1'b0);

    send(8'h41, 1'b1, 1'b0);
    advance(5);  check("b41_hi", oLCD_Data, 4'h4); check("b41_rs", oLCD_RegisterSelect, 1'b1);
    advance(65); check("b41_lo", oLCD_Data, 4'h1); check("b41_rs_lo", oLCD_RegisterSelect, 1'b1);

    // Back-to-back with iValid held and iData disturbed mid-transaction.
    wait_ready();
    iValid = 1'b1; iData = 8'h28; iRegisterSelect = 1'b0; iNibbleOnly = 1'b0;
    @(posedge Clock); #1;
    iData = 8'h3C; iRegisterSelect = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(posedge Clock); #1;
      n++;
      if (n == 30)   iData = 8'hA5;
      if (n == 1500) iData = 8'h3C;
      if (oReady === 1'b1) break;
    end
    check("b2b_edge", n + 1, 2082);
    @(posedge Clock); #1;
    iValid = 1'b0;
    advance(5); check("b2b_hi", oLCD_Data, 4'h3); check("b2b_rs", oLCD_RegisterSelect, 1'b1);

    // Reset in the middle of the low-nibble enable pulse.
    send(8'h35, 1'b1, 1'b0);
    advance(70); check("pre_rst_e", oLCD_Enabled, 1'b1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    check("abort_e", oLCD_Enabled, 1'b0);
    check("abort_ready", oReady, 1'b1);
    advance(200);
    send(8'h0C, 1'b0, 1'b0);
    wait_ready();

    repeat (20000) begin
      @(posedge Clock); #1;
      iValid          = ($urandom_range(3) == 0);
      iData           = 8'($urandom);
      iRegisterSelect = 1'($urandom);
      iNibbleOnly     = ($urandom_range(3) == 0);
      Reset           = ($urandom_range(4999) == 0);
    end
    iValid = 1'b0; Reset = 1'b0;
    wait_ready();
    repeat (3) @(posedge Clock);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
